vga_fb_arbiter: RTL and testbench

- Shares one single-port pixel SRAM between the VGA scan-out path and a host pixel-write stream, such as the ANN result or drawing logic.
- Sits between VGA_Controller (oRequest, Draw_X, Draw_Y) and the SRAM pins.
- VGA reads have absolute priority.
- Host writes are buffered in a small FIFO and drained in cycles with no VGA read.
- A hardware clear-screen sequencer fills the frame with a constant colour using the same free cycles.

---
 rtl/vga_fb_pkg.sv | 25 ++
 rtl/vga_fb_arbiter_if.sv | 53 +++++
 rtl/vga_fb_wr_fifo.sv | 65 ++++++
 rtl/vga_fb_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_fb_pkg.sv
// Shared constants, FSM state type and address helper for the VGA frame-buffer arbiter.
package vga_fb_pkg;

    localparam int H_ACT      = 640;
    localparam int V_ACT      = 480;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 19;
    localparam int COORD_W    = 10;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_W-1:0] CLEAR_COLOR = 16'h0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLR_WAIT = 2'd1,
        CLR_RUN  = 2'd2
    } fb_state_e;

    // Row-major packing: row in the upper 9 bits, column in the lower 10.
    function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y);
        return {y[8:0], x};
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Bundle of VGA request, host write, clear and SRAM pin signals of the arbiter.
interface vga_fb_arbiter_if
    import vga_fb_pkg::*;
#(
    parameter int IF_DATA_W = DATA_W,
    parameter int IF_ADDR_W = ADDR_W,
    parameter int IF_LVL_W  = LVL_W
) ();

    logic                 iVGA_Req;
    logic [9:0]           iVGA_X;
    logic [9:0]           iVGA_Y;
    logic [IF_DATA_W-1:0] oVGA_Pixel;

    logic                 iWr_Valid;
    logic                 oWr_Ready;
    logic [9:0]           iWr_X;
    logic [9:0]           iWr_Y;
    logic [IF_DATA_W-1:0] iWr_Data;

    logic                 iClear;
    logic                 oClear_Busy;
    logic [IF_LVL_W-1:0]  oFifo_Level;

    logic [IF_ADDR_W-1:0] oSRAM_Addr;
    logic [IF_DATA_W-1:0] oSRAM_WData;
    logic                 oSRAM_WE;
    logic                 oSRAM_OE;
    logic [IF_DATA_W-1:0] iSRAM_RData;

    modport slave (
        input  iVGA_Req, iVGA_X, iVGA_Y,
        output oVGA_Pixel,
        input  iWr_Valid, iWr_X, iWr_Y, iWr_Data,
        output oWr_Ready,
        input  iClear,
        output oClear_Busy, oFifo_Level,
        output oSRAM_Addr, oSRAM_WData, oSRAM_WE, oSRAM_OE,
        input  iSRAM_RData
    );

    modport master (
        output iVGA_Req, iVGA_X, iVGA_Y,
        input  oVGA_Pixel,
        output iWr_Valid, iWr_X, iWr_Y, iWr_Data,
        input  oWr_Ready,
        output iClear,
        input  oClear_Busy, oFifo_Level,
        input  oSRAM_Addr, oSRAM_WData, oSRAM_WE, oSRAM_OE,
        output iSRAM_RData
    );

endinterface

// File: rtl/vga_fb_wr_fifo.sv
// Small synchronous FIFO buffering host pixel writes ({X, Y, data} entries).
// DEPTH must be a power of two so the pointers wrap naturally.
module vga_fb_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] cnt_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o  = (cnt_q == DEPTH_L);
    assign empty_o = (cnt_q == {LVL_W{1'b0}});
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_ok_s = push_i && (!full_o || pop_i);
    assign pop_ok_s  = pop_i && !empty_o;
    assign head_o    = mem_q[rd_ptr_q];
    assign level_o   = cnt_q;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            cnt_q    <= {LVL_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            cnt_q <= cnt_q + {{(LVL_W-1){1'b0}}, push_ok_s} - {{(LVL_W-1){1'b0}}, pop_ok_s};
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port pixel SRAM arbiter: VGA reads win every cycle, buffered host
// writes drain in free cycles, and a clear sequencer sweeps the frame with
// CLEAR_COLOR using whatever free cycles remain.
module vga_fb_arbiter #(
    parameter int H_ACT      = vga_fb_pkg::H_ACT,
    parameter int V_ACT      = vga_fb_pkg::V_ACT,
    parameter int FIFO_DEPTH = vga_fb_pkg::FIFO_DEPTH,
    parameter logic [vga_fb_pkg::DATA_W-1:0] CLEAR_COLOR = vga_fb_pkg::CLEAR_COLOR
) (
    input  logic              iCLK,
    input  logic              iRST,
    vga_fb_arbiter_if.slave   bus
);

    import vga_fb_pkg::*;

    localparam int LW    = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = 2 * COORD_W + DATA_W;
    localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_ACT - 1);
    localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_ACT - 1);
    localparam logic [LW-1:0]      DEPTH_L = LW'(FIFO_DEPTH);

    fb_state_e           state_q, state_d;
    logic [COORD_W-1:0]  clr_x_q, clr_x_d;
    logic [COORD_W-1:0]  clr_y_q, clr_y_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q,    we_d;
    logic                oe_q,    oe_d;
    logic [DATA_W-1:0]   pixel_q, pixel_d;
    logic                rdy_q,   rdy_d;

    logic                push_s;
    logic                pop_s;
    logic                clr_wr_s;
    logic [ENT_W-1:0]    head_s;
    logic [COORD_W-1:0]  head_x_s;
    logic [COORD_W-1:0]  head_y_s;
    logic [DATA_W-1:0]   head_data_s;
    logic                head_in_range_s;
    logic [LW-1:0]       fifo_level_s;
    logic [LW-1:0]       level_nx_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;

    assign push_s          = bus.iWr_Valid && rdy_q;
    assign head_x_s        = head_s[ENT_W-1 -: COORD_W];
    assign head_y_s        = head_s[DATA_W +: COORD_W];
    assign head_data_s     = head_s[DATA_W-1:0];
    // Off-screen writes still consume their FIFO slot but never reach the SRAM.
    assign head_in_range_s = (head_x_s <= H_LAST) && (head_y_s <= V_LAST);
    assign level_nx_s      = fifo_level_s + {{(LW-1){1'b0}}, push_s} - {{(LW-1){1'b0}}, pop_s};

    vga_fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_wr_fifo (
        .clk_i       (iCLK),
        .rst_i       (iRST),
        .push_i      (push_s),
        .push_data_i ({bus.iWr_X, bus.iWr_Y, bus.iWr_Data}),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .level_o     (fifo_level_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    // Slot owner for this cycle: VGA read, then FIFO drain, then clear sweep.
    always_comb begin
        pop_s    = 1'b0;
        clr_wr_s = 1'b0;
        if (bus.iVGA_Req) begin
            pop_s = 1'b0;
        end else if (!fifo_empty_s && (state_q == IDLE || state_q == CLR_WAIT)) begin
            pop_s = 1'b1;
        end else if (state_q == CLR_RUN) begin
            clr_wr_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Next SRAM pin values; address/data hold when the slot is unused.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        oe_d    = 1'b0;
        if (bus.iVGA_Req) begin
            oe_d   = 1'b1;
            addr_d = xy_to_addr(bus.iVGA_X, bus.iVGA_Y);
        end else if (pop_s && head_in_range_s) begin
            we_d    = 1'b1;
            addr_d  = xy_to_addr(head_x_s, head_y_s);
            wdata_d = head_data_s;
        end else if (clr_wr_s) begin
            we_d    = 1'b1;
            addr_d  = xy_to_addr(clr_x_q, clr_y_q);
            wdata_d = CLEAR_COLOR;
        end else begin
            we_d = 1'b0;
        end
    end

    // Clear sequencer next state and sweep counters.
    always_comb begin
        state_d = state_q;
        clr_x_d = clr_x_q;
        clr_y_d = clr_y_q;
        case (state_q)
            IDLE: begin
                if (bus.iClear) begin
                    state_d = CLR_WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            CLR_WAIT: begin
                // Pending host writes must land before the sweep starts.
                if (fifo_empty_s) begin
                    state_d = CLR_RUN;
                    clr_x_d = {COORD_W{1'b0}};
                    clr_y_d = {COORD_W{1'b0}};
                end else begin
                    state_d = CLR_WAIT;
                end
            end
            CLR_RUN: begin
                if (clr_wr_s) begin
                    if (clr_x_q == H_LAST) begin
                        clr_x_d = {COORD_W{1'b0}};
                        if (clr_y_q == V_LAST) begin
                            clr_y_d = {COORD_W{1'b0}};
                            state_d = IDLE;
                        end else begin
                            clr_y_d = clr_y_q + 10'd1;
                        end
                    end else begin
                        clr_x_d = clr_x_q + 10'd1;
                    end
                end else begin
                    state_d = CLR_RUN;
                end
            end
            default: begin
                state_d = IDLE;
                clr_x_d = {COORD_W{1'b0}};
                clr_y_d = {COORD_W{1'b0}};
            end
        endcase
    end

    // Read data returns one cycle after OE; otherwise the last pixel is held.
    always_comb begin
        if (oe_q) begin
            pixel_d = bus.iSRAM_RData;
        end else begin
            pixel_d = pixel_q;
        end
    end

    // Ready is registered from next-cycle occupancy and state so it drops the
    // same cycle the FIFO fills or a clear is requested.
    always_comb begin
        if ((level_nx_s < DEPTH_L) && (state_d == IDLE)) begin
            rdy_d = 1'b1;
        end else begin
            rdy_d = 1'b0;
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            clr_x_q <= {COORD_W{1'b0}};
            clr_y_q <= {COORD_W{1'b0}};
            addr_q  <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            pixel_q <= {DATA_W{1'b0}};
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_x_q <= clr_x_d;
            clr_y_q <= clr_y_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            pixel_q <= pixel_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.oSRAM_Addr  = addr_q;
    assign bus.oSRAM_WData = wdata_q;
    assign bus.oSRAM_WE    = we_q;
    assign bus.oSRAM_OE    = oe_q;
    assign bus.oVGA_Pixel  = pixel_q;
    assign bus.oWr_Ready   = rdy_q;
    assign bus.oClear_Busy = (state_q != IDLE);
    assign bus.oFifo_Level = fifo_level_s;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter on a reduced 32x32 frame so a full
// clear sweep fits in a short run. A transaction-level model (write queue,
// linear clear index) predicts every SRAM pin, pixel, level, ready and busy.
module tb_vga_fb_arbiter;

    localparam int TH = 32;
    localparam int TV = 32;
    localparam int TD = 4;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] d;
    } wr_t;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;

    vga_fb_arbiter_if bus ();

    vga_fb_arbiter #(
        .H_ACT       (TH),
        .V_ACT       (TV),
        .FIFO_DEPTH  (TD),
        .CLEAR_COLOR (16'h0000)
    ) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    always #5 iCLK = ~iCLK;

    wr_t         q[$];
    bit          m_pend, m_act;
    int          m_idx;
    logic        m_we, m_oe, m_rdy;
    logic [18:0] m_addr;
    logic [15:0] m_wd, m_pix;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pend = 1'b0; m_act = 1'b0; m_idx = 0;
        m_we = 1'b0; m_oe = 1'b0; m_rdy = 1'b0;
        m_addr = 19'h0; m_wd = 16'h0; m_pix = 16'h0;
    endtask

    task automatic check_model();
        chk("we",     32'(bus.oSRAM_WE),    32'(m_we));
        chk("oe",     32'(bus.oSRAM_OE),    32'(m_oe));
        chk("addr",   32'(bus.oSRAM_Addr),  32'(m_addr));
        chk("wdata",  32'(bus.oSRAM_WData), 32'(m_wd));
        chk("pixel",  32'(bus.oVGA_Pixel),  32'(m_pix));
        chk("level",  32'(bus.oFifo_Level), 32'(q.size()));
        chk("ready",  32'(bus.oWr_Ready),   32'(m_rdy));
        chk("busy",   32'(bus.oClear_Busy), 32'(m_pend || m_act));
    endtask

    task automatic check_reset_state();
        chk("rst_we",    32'(bus.oSRAM_WE),    32'd0);
        chk("rst_oe",    32'(bus.oSRAM_OE),    32'd0);
        chk("rst_addr",  32'(bus.oSRAM_Addr),  32'd0);
        chk("rst_wdata", 32'(bus.oSRAM_WData), 32'd0);
        chk("rst_pixel", 32'(bus.oVGA_Pixel),  32'd0);
        chk("rst_level", 32'(bus.oFifo_Level), 32'd0);
        chk("rst_ready", 32'(bus.oWr_Ready),   32'd0);
        chk("rst_busy",  32'(bus.oClear_Busy), 32'd0);
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input logic req, input logic [9:0] vx, input logic [9:0] vy,
                        input logic wv, input logic [9:0] wx, input logic [9:0] wy,
                        input logic [15:0] wd, input logic clr, input logic [15:0] rd);
        bit   acc, busy0;
        int   pre;
        wr_t  h;
        logic [9:0] cx, cy;
        bus.iVGA_Req = req;  bus.iVGA_X = vx;  bus.iVGA_Y = vy;
        bus.iWr_Valid = wv;  bus.iWr_X = wx;   bus.iWr_Y = wy;  bus.iWr_Data = wd;
        bus.iClear = clr;    bus.iSRAM_RData = rd;
        acc   = wv && m_rdy;
        pre   = q.size();
        busy0 = m_pend || m_act;
        if (m_oe) m_pix = rd;
        m_we = 1'b0;
        m_oe = 1'b0;
        if (req) begin
            m_oe   = 1'b1;
            m_addr = {vy[8:0], vx};
        end else if (pre > 0 && !m_act) begin
            h = q.pop_front();
            if (h.x < TH && h.y < TV) begin
                m_we = 1'b1; m_addr = {h.y[8:0], h.x}; m_wd = h.d;
            end
        end else if (m_act) begin
            cx = 10'(m_idx % TH);
            cy = 10'(m_idx / TH);
            m_we = 1'b1; m_addr = {cy[8:0], cx}; m_wd = 16'h0000;
            m_idx++;
            if (m_idx == TH * TV) m_act = 1'b0;
        end
        if (acc) q.push_back('{x: wx, y: wy, d: wd});
        if (m_pend && pre == 0) begin
            m_pend = 1'b0; m_act = 1'b1; m_idx = 0;
        end
        if (!busy0 && clr) m_pend = 1'b1;
        m_rdy = (q.size() < TD) && !(m_pend || m_act);
        @(posedge iCLK);
        #1;
        check_model();
    endtask

    task automatic idle_step();
        step(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 16'h0, 1'b0, 16'($urandom));
    endtask

    initial begin
        int guard;
        bus.iVGA_Req = 1'b0; bus.iVGA_X = 10'd0; bus.iVGA_Y = 10'd0;
        bus.iWr_Valid = 1'b0; bus.iWr_X = 10'd0; bus.iWr_Y = 10'd0; bus.iWr_Data = 16'h0;
        bus.iClear = 1'b0; bus.iSRAM_RData = 16'h0;
        model_reset();

        // Reset state
        repeat (3) @(posedge iCLK);
        #1;
        check_reset_state();
        iRST = 1'b0;
        idle_step();
        chk("ready_after_rst", 32'(bus.oWr_Ready), 32'd1);

        // Isolated read at (5,3)
        step(1'b1, 10'd5, 10'd3, 1'b0, 10'd0, 10'd0, 16'h0, 1'b0, 16'h0);
        chk("rd_addr_const", 32'(bus.oSRAM_Addr), 32'h00C05);
        step(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 16'h0, 1'b0, 16'hABCD);
        chk("rd_pixel_const", 32'(bus.oVGA_Pixel), 32'h0000ABCD);

        // Single write during blanking at (10,20)
        step(1'b0, 10'd0, 10'd0, 1'b1, 10'd10, 10'd20, 16'h1234, 1'b0, 16'h0);
        idle_step();
        chk("wr_we_const", 32'(bus.oSRAM_WE), 32'd1);
        chk("wr_addr_const", 32'(bus.oSRAM_Addr), 32'h0500A);
        chk("wr_data_const", 32'(bus.oSRAM_WData), 32'h1234);
        chk("wr_level_const", 32'(bus.oFifo_Level), 32'd0);

        // Contention: 640-cycle read burst with 5 write attempts
        for (int i = 0; i < 640; i++) begin
            step(1'b1, 10'(i % TH), 10'(i / TH), (i < 5), 10'(i), 10'd1,
                 16'(16'h100 + i), 1'b0, 16'($urandom));
            if (i == 3) chk("full_ready", 32'(bus.oWr_Ready), 32'd0);
        end
        chk("burst_level", 32'(bus.oFifo_Level), 32'd4);
        for (int i = 0; i < 6; i++) idle_step();

        // Randomised mix of reads, writes (some off-screen) and clears
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 100) < 55, 10'($urandom % TH), 10'($urandom % TV),
                 ($urandom % 2) == 1, 10'($urandom % 40), 10'($urandom % 36),
                 16'($urandom), ($urandom % 400) == 0, 16'($urandom));
        end
        guard = 0;
        while ((m_pend || m_act) && guard < 5000) begin
            idle_step();
            guard++;
        end
        chk("random_drain", 32'(bus.oClear_Busy), 32'd0);

        // Clear with two queued writes plus a write accepted with iClear
        step(1'b1, 10'd1, 10'd1, 1'b1, 10'd3, 10'd4, 16'hBEEF, 1'b0, 16'h0);
        step(1'b1, 10'd2, 10'd1, 1'b1, 10'd5, 10'd6, 16'hCAFE, 1'b0, 16'h0);
        chk("pre_clear_level", 32'(bus.oFifo_Level), 32'd2);
        step(1'b0, 10'd0, 10'd0, 1'b1, 10'd7, 10'd8, 16'hF00D, 1'b1, 16'h0);
        chk("clear_busy", 32'(bus.oClear_Busy), 32'd1);
        guard = 0;
        while ((m_pend || m_act) && guard < 6000) begin
            step(($urandom % 100) < 40, 10'($urandom % TH), 10'($urandom % TV),
                 1'b1, 10'd9, 10'd9, 16'h7777, ($urandom % 10) == 0, 16'($urandom));
            guard++;
        end
        chk("clear_done", 32'(bus.oClear_Busy), 32'd0);
        chk("clear_last_addr", 32'(bus.oSRAM_Addr), 32'({9'(TV - 1), 10'(TH - 1)}));

        // Reset during a clear sweep at row 10
        for (int i = 0; i < 4; i++) idle_step();
        step(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 16'h0, 1'b1, 16'h0);
        guard = 0;
        while (m_idx < 10 * TH && guard < 3000) begin
            step(($urandom % 100) < 30, 10'($urandom % TH), 10'($urandom % TV),
                 1'b0, 10'd0, 10'd0, 16'h0, 1'b0, 16'($urandom));
            guard++;
        end
        chk("mid_clear_busy", 32'(bus.oClear_Busy), 32'd1);
        #2;
        iRST = 1'b1;
        #1;
        check_reset_state();
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        model_reset();
        for (int i = 0; i < 100; i++) idle_step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
